// File: rtl/cap_frame_ctrl.sv
// Frame-capture sequencer: gates the decoder's vsync/hsync/pdata so only whole frames reach the pixel path.
// Optional per-line/per-frame geometry check is built when CAP_LINE_CHECK_EN is defined.
module cap_frame_ctrl #(
    parameter int DW        = 8,
    parameter int EXP_LINES = 1080,
    parameter int EXP_COLS  = 1920,
    parameter int TO_W      = 24,
    parameter int TIMEOUT   = 4000000,
    parameter int FCNT_W    = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              hsync,
    input  logic [DW-1:0]     pdata,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_single,
    input  logic [3:0]        cfg_decim,
    output logic              cap_vsync,
    output logic              cap_hsync,
    output logic [DW-1:0]     cap_data,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              timeout,
    output logic              line_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    state_e              state_q;
    logic                vsync_q;
    logic [3:0]          skip_q;
    logic [3:0]          decim_q;
    logic                single_q;
    logic                stop_pend_q;
    logic [TO_W-1:0]     wd_q;
    logic                cap_vsync_q;
    logic                cap_hsync_q;
    logic [DW-1:0]       cap_data_q;
    logic                frame_done_q;
    logic [FCNT_W-1:0]   frame_cnt_q;
    logic                timeout_q;

    logic vs_rise;
    logic start_ok;
    logic wd_hit;
    logic cap_end;
    logic cap_exit;
    logic arm_hit;
    logic gate;

    // NOTE: every signal assigned here gets its value on every path, so no latch is inferred.
    always_comb begin
        vs_rise  = vsync & ~vsync_q;
        start_ok = (state_q == IDLE) & start & ~stop;
        wd_hit   = (state_q != IDLE) & ~vs_rise & (wd_q == TO_W'(TIMEOUT - 1));
        cap_end  = (state_q == CAPTURE) & vs_rise;
        cap_exit = cap_end & (single_q | stop_pend_q | stop | (decim_q != 4'd0));
        arm_hit  = (state_q == ARM) & vs_rise & (skip_q == 4'd0) & ~stop;
        gate     = ((state_q == CAPTURE) & ~cap_exit) | arm_hit;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            skip_q       <= 4'd0;
            decim_q      <= 4'd0;
            single_q     <= 1'b0;
            stop_pend_q  <= 1'b0;
            wd_q         <= '0;
            cap_vsync_q  <= 1'b0;
            cap_hsync_q  <= 1'b0;
            cap_data_q   <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            frame_done_q <= 1'b0;
            cap_vsync_q  <= vsync & gate;
            cap_hsync_q  <= hsync & gate;
            cap_data_q   <= gate ? pdata : '0;

            if (state_q == IDLE || vs_rise) begin
                wd_q <= '0;
            end else if (wd_q != {TO_W{1'b1}}) begin
                wd_q <= wd_q + TO_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q     <= ARM;
                        skip_q      <= 4'd0;
                        decim_q     <= cfg_decim;
                        single_q    <= cfg_single;
                        stop_pend_q <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                ARM: begin
                    if (wd_hit) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else if (stop) begin
                        state_q <= IDLE;
                    end else if (vs_rise) begin
                        if (skip_q == 4'd0) state_q <= CAPTURE;
                        else                skip_q  <= skip_q - 4'd1;
                    end
                end
                CAPTURE: begin
                    if (wd_hit) begin
                        state_q     <= IDLE;
                        timeout_q   <= 1'b1;
                        stop_pend_q <= 1'b0;
                    end else if (vs_rise) begin
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + FCNT_W'(1);
                        if (single_q | stop_pend_q | stop) begin
                            state_q     <= IDLE;
                            stop_pend_q <= 1'b0;
                        end else if (decim_q != 4'd0) begin
                            // The rise that ends this frame also opens the first skipped one.
                            state_q <= ARM;
                            skip_q  <= decim_q - 4'd1;
                        end
                    end else if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cap_vsync  = cap_vsync_q;
    assign cap_hsync  = cap_hsync_q;
    assign cap_data   = cap_data_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign timeout    = timeout_q;

`ifdef CAP_LINE_CHECK_EN
    localparam int LW = $clog2(EXP_LINES + 2);
    localparam int CW = $clog2(EXP_COLS + 2);

    logic          hsync_q;
    logic [LW-1:0] lines_q;
    logic [CW-1:0] pix_q;
    logic          line_err_q;
    logic          frame_start;
    logic          hs_rise;
    logic          hs_fall;

    always_comb begin
        frame_start = arm_hit | (cap_end & ~cap_exit);
        hs_rise     = hsync & ~hsync_q;
        hs_fall     = ~hsync & hsync_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            hsync_q    <= 1'b0;
            lines_q    <= '0;
            pix_q      <= '0;
            line_err_q <= 1'b0;
        end else begin
            hsync_q <= hsync;
            if (start_ok) line_err_q <= 1'b0;
            if (cap_end && lines_q != LW'(EXP_LINES)) line_err_q <= 1'b1;

            if (frame_start) begin
                lines_q <= '0;
                pix_q   <= '0;
            end else if (state_q == CAPTURE) begin
                if (hs_rise) begin
                    if (lines_q != {LW{1'b1}}) lines_q <= lines_q + LW'(1);
                    pix_q <= CW'(1);
                end else if (hsync && pix_q != {CW{1'b1}}) begin
                    pix_q <= pix_q + CW'(1);
                end
                if (hs_fall && pix_q != CW'(EXP_COLS)) line_err_q <= 1'b1;
            end
        end
    end

    assign line_err = line_err_q;
`else
    assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_cap_frame_ctrl.sv
// Bench for cap_frame_ctrl: scenario table plus hand sequences, scoreboard on the gated pixel bus.
module tb_cap_frame_ctrl;

    localparam int DW    = 8;
    localparam int LINES = 4;
    localparam int COLS  = 8;
    localparam int TMO   = 1000;
    localparam int FW    = 16;
`ifdef CAP_LINE_CHECK_EN
    localparam logic LE_SHORT = 1'b1;
`else
    localparam logic LE_SHORT = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          rst_n;
    logic          vsync, hsync, start, stop, cfg_single;
    logic [DW-1:0] pdata;
    logic [3:0]    cfg_decim;
    logic          cap_vsync, cap_hsync, busy, frame_done, timeout, line_err;
    logic [DW-1:0] cap_data;
    logic [FW-1:0] frame_cnt;

    always #5 pclk = ~pclk;

    cap_frame_ctrl #(
        .DW(DW), .EXP_LINES(LINES), .EXP_COLS(COLS),
        .TO_W(24), .TIMEOUT(TMO), .FCNT_W(FW)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync), .pdata(pdata),
        .start(start), .stop(stop), .cfg_single(cfg_single), .cfg_decim(cfg_decim),
        .cap_vsync(cap_vsync), .cap_hsync(cap_hsync), .cap_data(cap_data),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .timeout(timeout), .line_err(line_err)
    );

    typedef struct {
        logic [3:0] decim;
        logic       single;
        int         nfr;
        int         stop_fr;
        logic [7:0] cap_mask;
        int         exp_done;
        logic       exp_busy;
    } scen_t;

    int              checks = 0;
    int              errors = 0;
    int              done_seen = 0;
    logic [DW+1:0]   sb_q[$];
    scen_t           tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        logic [DW+1:0] e;
        if (frame_done) done_seen++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("cap_bus", 64'({cap_vsync, cap_hsync, cap_data}), 64'(e));
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic st, input logic sp, input logic cap);
        logic [DW-1:0] r;
        @(negedge pclk);
        sample();
        r = DW'($urandom);
        vsync = vs; hsync = hs; pdata = r; start = st; stop = sp;
        sb_q.push_back(cap ? {vs, hs, r} : '0);
    endtask

    task automatic flush();
        @(negedge pclk);
        sample();
        vsync = 1'b0; hsync = 1'b0; pdata = '0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic drive_frame(input logic cap, input int stop_at, input int short_line);
        int c;
        int n;
        c = 0;
        for (int i = 0; i < 2; i++) begin step(1'b1, 1'b0, 1'b0, c == stop_at, cap); c++; end
        for (int l = 0; l < LINES; l++) begin
            n = (l == short_line) ? COLS - 1 : COLS;
            for (int p = 0; p < n; p++) begin step(1'b0, 1'b1, 1'b0, c == stop_at, cap); c++; end
            for (int g = 0; g < 2; g++) begin step(1'b0, 1'b0, 1'b0, c == stop_at, cap); c++; end
        end
        for (int t = 0; t < 2; t++) begin step(1'b0, 1'b0, 1'b0, c == stop_at, cap); c++; end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst_n = 1'b0;
        vsync = 1'b0; hsync = 1'b0; pdata = '0; start = 1'b0; stop = 1'b0;
        cfg_single = 1'b0; cfg_decim = 4'd0;
        sb_q.delete();
        repeat (3) @(negedge pclk);
        check("reset_state",
              64'({busy, frame_done, frame_cnt, timeout, line_err, cap_vsync, cap_hsync, cap_data}), 64'd0);
        rst_n = 1'b1;
        done_seen = 0;
    endtask

    initial begin
        // decim, single, frames, stop frame, captured-frame mask, frame_done count, busy at end
        tbl[0] = '{4'd0, 1'b0, 4, 2,  8'b0000_0111, 3, 1'b0};
        tbl[1] = '{4'd2, 1'b0, 7, -1, 8'b0100_1001, 2, 1'b1};
        tbl[2] = '{4'd0, 1'b1, 3, -1, 8'b0000_0001, 1, 1'b0};
        tbl[3] = '{4'd0, 1'b0, 2, 0,  8'b0000_0001, 1, 1'b0};
        tbl[4] = '{4'd1, 1'b0, 5, -1, 8'b0001_0101, 2, 1'b1};
        tbl[5] = '{4'd0, 1'b0, 3, -1, 8'b0000_0111, 2, 1'b1};

        for (int s = 0; s < 6; s++) begin
            do_reset();
            cfg_decim  = tbl[s].decim;
            cfg_single = tbl[s].single;
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            // Configuration must have been latched at start, so scramble the live inputs.
            cfg_decim  = ~tbl[s].decim;
            cfg_single = ~tbl[s].single;
            for (int f = 0; f < tbl[s].nfr; f++)
                drive_frame(tbl[s].cap_mask[f], (f == tbl[s].stop_fr) ? 20 : -1, -1);
            flush();
            check($sformatf("s%0d_done_pulses", s), 64'(done_seen), 64'(tbl[s].exp_done));
            check($sformatf("s%0d_frame_cnt", s), 64'(frame_cnt), 64'(tbl[s].exp_done));
            check($sformatf("s%0d_busy", s), 64'(busy), 64'(tbl[s].exp_busy));
            check($sformatf("s%0d_line_err", s), 64'(line_err), 64'd0);
        end

        // Start together with stop, and stop alone, are both ignored in IDLE.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        flush();
        check("start_stop_idle_busy", 64'(busy), 64'd0);

        // Single shot; a start coincident with the closing vsync rise is ignored.
        do_reset();
        cfg_single = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_frame(1'b1, -1, -1);
        check("single_busy_in_frame", 64'(busy), 64'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("single_busy_after_rise", 64'(busy), 64'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush();
        check("single_done_pulses", 64'(done_seen), 64'd1);
        check("single_frame_cnt", 64'(frame_cnt), 64'd1);

        // Line geometry: one short line flags line_err when checking is built; next start clears it.
        do_reset();
        cfg_single = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_frame(1'b1, -1, 1);
        drive_frame(1'b0, -1, -1);
        flush();
        check("short_line_err", 64'(line_err), 64'(LE_SHORT));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("line_err_cleared", 64'(line_err), 64'd0);
        drive_frame(1'b1, -1, -1);
        drive_frame(1'b0, -1, -1);
        flush();
        check("clean_line_err", 64'(line_err), 64'd0);
        check("clean_done_pulses", 64'(done_seen), 64'd2);

        // Watchdog is cleared by a vsync rise, so two sub-timeout gaps keep capture alive.
        do_reset();
        @(negedge pclk); start = 1'b1;
        @(negedge pclk); start = 1'b0;
        repeat (TMO - 200) @(negedge pclk);
        vsync = 1'b1;
        @(negedge pclk); vsync = 1'b0;
        repeat (TMO - 200) @(negedge pclk);
        check("wd_cleared_busy", 64'({busy, timeout}), 64'b10);

        // Watchdog expiry: TIMEOUT cycles in ARM without a vsync rise.
        do_reset();
        @(negedge pclk); start = 1'b1;
        @(posedge pclk); #1 start = 1'b0;
        repeat (TMO - 1) @(posedge pclk);
        #1 check("timeout_before", 64'({busy, timeout}), 64'b10);
        @(posedge pclk);
        #1 check("timeout_after", 64'({busy, timeout}), 64'b01);
        check("timeout_no_frame", 64'({frame_done, frame_cnt}), 64'd0);
        @(negedge pclk); start = 1'b1;
        @(negedge pclk); start = 1'b0;
        check("timeout_cleared", 64'({busy, timeout}), 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
